// File: rtl/fpu_pkg.sv
// Shared build constants and types for the FPU operand issue path.
package fpu_pkg;

`ifdef FPU16
   localparam int FPU_WIDTH = 16;
`elsif FPU64
   localparam int FPU_WIDTH = 64;
`else
   localparam int FPU_WIDTH = 32;
`endif

   localparam int ISSUED_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BOTH   = 2'd1,
      WAIT_A = 2'd2,
      WAIT_B = 2'd3
   } issue_state_e;

endpackage

// File: rtl/fpu_pair_fifo.sv
// Operand-pair FIFO with occupancy count and combinational head read.
module fpu_pair_fifo #(
   parameter int DW    = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [DW-1:0]            data_i,
   input  logic                     pop_i,
   output logic [DW-1:0]            head_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   // Guard against over/underflow even though the issuer never requests it.
   assign do_push = push_i && (count_q != (AW+1)'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/fpu_operand_issuer.sv
// Issues buffered (a, b) pairs to fpu_adder over its split stb/ack handshakes.
module fpu_operand_issuer
   import fpu_pkg::*;
#(
   parameter int WIDTH = FPU_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         input_a,
   output logic [WIDTH-1:0]         input_b,
   output logic                     input_a_stb,
   output logic                     input_b_stb,
   input  logic                     input_a_ack,
   input  logic                     input_b_ack,
   output logic [$clog2(DEPTH):0]   pending,
   output logic [ISSUED_W-1:0]      issued
);
   localparam int CW = $clog2(DEPTH) + 1;

   issue_state_e          state_q;
   logic                  a_stb_q, b_stb_q;
   logic [ISSUED_W-1:0]   issued_q;
   logic [2*WIDTH-1:0]    head;
   logic                  push, a_xfer, b_xfer, fin, more;

   assign in_ready = (pending != CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign a_xfer   = a_stb_q && input_a_ack;
   assign b_xfer   = b_stb_q && input_b_ack;
   // Another pair is ready to issue straight after this one completes.
   assign more     = (pending > CW'(1)) || push;

   always_comb begin
      fin = 1'b0;
      case (state_q)
         BOTH:    fin = a_xfer && b_xfer;
         WAIT_A:  fin = a_xfer;
         WAIT_B:  fin = b_xfer;
         default: fin = 1'b0;
      endcase
   end

   fpu_pair_fifo #(
      .DW    (2*WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (push),
      .data_i  ({in_b, in_a}),
      .pop_i   (fin),
      .head_o  (head),
      .count_o (pending)
   );

   assign input_a     = head[WIDTH-1:0];
   assign input_b     = head[2*WIDTH-1:WIDTH];
   assign input_a_stb = a_stb_q;
   assign input_b_stb = b_stb_q;
   assign issued      = issued_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         a_stb_q  <= 1'b0;
         b_stb_q  <= 1'b0;
         issued_q <= '0;
      end else begin
         if (fin) issued_q <= issued_q + 1'b1;
         case (state_q)
            IDLE: begin
               if (pending != '0) begin
                  state_q <= BOTH;
                  a_stb_q <= 1'b1;
                  b_stb_q <= 1'b1;
               end
            end
            BOTH: begin
               if (fin) begin
                  state_q <= more ? BOTH : IDLE;
                  a_stb_q <= more;
                  b_stb_q <= more;
               end else if (a_xfer) begin
                  state_q <= WAIT_B;
                  a_stb_q <= 1'b0;
               end else if (b_xfer) begin
                  state_q <= WAIT_A;
                  b_stb_q <= 1'b0;
               end
            end
            WAIT_A, WAIT_B: begin
               if (fin) begin
                  state_q <= more ? BOTH : IDLE;
                  a_stb_q <= more;
                  b_stb_q <= more;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_operand_issuer.sv
// Directed checks of the operand issuer, plus a long in-order wrap run.
module tb_fpu_operand_issuer;
   import fpu_pkg::*;

   localparam int W  = 32;
   localparam int D  = 4;
   localparam int CW = $clog2(D) + 1;
   localparam int TOTAL = 70000;
   localparam int LIMIT = 90000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [W-1:0]  in_a = '0, in_b = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  input_a, input_b;
   logic          input_a_stb, input_b_stb;
   logic          input_a_ack = 1'b0, input_b_ack = 1'b0;
   logic [CW-1:0] pending;
   logic [15:0]   issued;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fpu_operand_issuer #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
      .input_a(input_a), .input_b(input_b),
      .input_a_stb(input_a_stb), .input_b_stb(input_b_stb),
      .input_a_ack(input_a_ack), .input_b_ack(input_b_ack),
      .pending(pending), .issued(issued)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] pa(input int i);
      return W'(32'h1000_0000 + i);
   endfunction
   function automatic logic [W-1:0] pb(input int i);
      return W'(32'h2000_0000 + i);
   endfunction
   function automatic logic [W-1:0] fa(input int i);
      logic [31:0] v;
      v = i * 32'd2654435761;
      return W'(v);
   endfunction
   function automatic logic [W-1:0] fb(input int i);
      return ~fa(i);
   endfunction

   task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
      in_a = a; in_b = b; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   int  ia, ib, bad, cyc;
   logic timeout;

   initial begin
      #1;
      chk("rst_a_stb", input_a_stb, 0);
      chk("rst_b_stb", input_b_stb, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_pending", pending, 0);
      chk("rst_issued", issued, 0);
      chk("rst_input_a", input_a, 0);
      step(); step();
      rst = 1'b1;
      step();

      // Single pair: a acked first, then b
      push_pair(32'h3F80_0000, 32'h4000_0000);
      chk("sp_pending", pending, 1);
      chk("sp_stb_early", {input_a_stb, input_b_stb}, 2'b00);
      step();
      chk("sp_stbs", {input_a_stb, input_b_stb}, 2'b11);
      chk("sp_a", input_a, 32'h3F80_0000);
      chk("sp_b", input_b, 32'h4000_0000);
      step();
      input_a_ack = 1'b1;
      step();
      input_a_ack = 1'b0;
      chk("sp_waitb0", {input_a_stb, input_b_stb}, 2'b01);
      step();
      chk("sp_waitb1", {input_a_stb, input_b_stb}, 2'b01);
      chk("sp_b_hold", input_b, 32'h4000_0000);
      input_b_ack = 1'b1;
      step();
      input_b_ack = 1'b0;
      chk("sp_issued", issued, 1);
      chk("sp_pend0", pending, 0);
      chk("sp_idle", {input_a_stb, input_b_stb}, 2'b00);

      // Fill to full with the adder stalled
      for (int i = 1; i <= 4; i++) push_pair(pa(i), pb(i));
      chk("full_ready", in_ready, 0);
      chk("full_pending", pending, 4);
      chk("full_head", input_a, pa(1));
      in_a = pa(5); in_b = pb(5); in_valid = 1'b1;
      step();
      chk("full_held", pending, 4);
      chk("full_ready2", in_ready, 0);
      input_a_ack = 1'b1; input_b_ack = 1'b1;
      step();
      chk("full_pop_ready", in_ready, 1);
      chk("full_pop_pend", pending, 3);
      chk("full_pop_head", input_a, pa(2));
      step();
      in_valid = 1'b0;
      chk("full_pushpop", pending, 3);
      chk("full_head3", input_a, pa(3));
      for (int i = 4; i <= 5; i++) begin
         step();
         chk("full_drain_a", input_a, pa(i));
         chk("full_drain_b", input_b, pb(i));
      end
      step();
      input_a_ack = 1'b0; input_b_ack = 1'b0;
      chk("full_issued", issued, 6);
      chk("full_empty", pending, 0);

      // Back-to-back issue with paired acks every cycle
      for (int i = 10; i < 14; i++) push_pair(pa(i), pb(i));
      input_a_ack = 1'b1; input_b_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("b2b_stbs", {input_a_stb, input_b_stb}, 2'b11);
         chk("b2b_a", input_a, pa(10 + k));
         chk("b2b_b", input_b, pb(10 + k));
         chk("b2b_issued", issued, 16'(6 + k));
         step();
      end
      input_a_ack = 1'b0; input_b_ack = 1'b0;
      chk("b2b_issued_end", issued, 10);
      chk("b2b_pend", pending, 0);
      chk("b2b_idle", {input_a_stb, input_b_stb}, 2'b00);

      // Reversed ack order
      push_pair(pa(20), pb(20));
      step();
      input_b_ack = 1'b1;
      step();
      input_b_ack = 1'b0;
      chk("rev_waita", {input_a_stb, input_b_stb}, 2'b10);
      chk("rev_a_hold", input_a, pa(20));
      step();
      chk("rev_waita2", {input_a_stb, input_b_stb}, 2'b10);
      chk("rev_pend", pending, 1);
      input_a_ack = 1'b1;
      step();
      input_a_ack = 1'b0;
      chk("rev_issued", issued, 11);
      chk("rev_pend0", pending, 0);

      // Async reset while in WAIT_B with three pairs held
      for (int i = 30; i < 33; i++) push_pair(pa(i), pb(i));
      input_a_ack = 1'b1;
      step();
      input_a_ack = 1'b0;
      chk("ar_waitb", {input_a_stb, input_b_stb}, 2'b01);
      chk("ar_pend3", pending, 3);
      #2 rst = 1'b0;
      #1;
      chk("ar_stbs", {input_a_stb, input_b_stb}, 2'b00);
      chk("ar_pending", pending, 0);
      chk("ar_ready", in_ready, 1);
      chk("ar_issued", issued, 0);
      chk("ar_input_a", input_a, 0);
      step();
      rst = 1'b1;
      step();
      push_pair(pa(40), pb(40));
      step();
      chk("ar_resume_stbs", {input_a_stb, input_b_stb}, 2'b11);
      chk("ar_resume_a", input_a, pa(40));
      input_a_ack = 1'b1; input_b_ack = 1'b1;
      step();
      input_a_ack = 1'b0; input_b_ack = 1'b0;
      chk("ar_resume_issued", issued, 1);

      // Wrap run: fresh reset, then 70000 pairs with occasional stalls
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      ia = 0; ib = 0; bad = 0; cyc = 0; timeout = 1'b0;
      fork
         begin
            for (int i = 0; i < TOTAL && !timeout; i++) begin
               logic acc;
               in_a = fa(i); in_b = fb(i); in_valid = 1'b1;
               do begin
                  acc = in_ready;
                  step();
               end while (!acc && !timeout);
            end
            in_valid = 1'b0;
         end
         begin
            while ((ia < TOTAL || ib < TOTAL) && !timeout) begin
               input_a_ack = ($urandom_range(63) != 0);
               input_b_ack = ($urandom_range(63) != 0);
               if (input_a_stb && input_a_ack) begin
                  if (input_a !== fa(ia)) bad++;
                  ia++;
               end
               if (input_b_stb && input_b_ack) begin
                  if (input_b !== fb(ib)) bad++;
                  ib++;
               end
               step();
               cyc++;
               if (cyc >= LIMIT) timeout = 1'b1;
            end
            input_a_ack = 1'b0; input_b_ack = 1'b0;
         end
      join
      chk("wrap_timeout", timeout, 0);
      chk("wrap_order_errs", bad, 0);
      chk("wrap_a_count", ia, TOTAL);
      chk("wrap_b_count", ib, TOTAL);
      chk("wrap_issued", issued, 16'(TOTAL % 65536));
      chk("wrap_pending", pending, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fpu_operand_issuer.md
# fpu_operand_issuer

Buffers (a, b) operand pairs arriving on a valid/ready stream and issues them to `fpu_adder` over its independent per-operand stb/ack handshakes. It sits directly upstream of `fpu_adder` and replaces testbench-driven stimulus in system-level and energy-characterisation runs. Pairs are issued in order, back-to-back when the adder allows.

## Interface

Parameters:
- `WIDTH`, 32: operand width, one of 16/32/64, matching the `FPU16`/`FPU32`/`FPU64` builds.
- `DEPTH`, 4: pair FIFO depth; power of two, at least 2.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; 0 resets the block.
- `in_a`  in  WIDTH  operand a of the incoming pair.
- `in_b`  in  WIDTH  operand b of the incoming pair.
- `in_valid`  in  1  the pair on `in_a`/`in_b` is valid.
- `in_ready`  out  1  FIFO can accept a pair.
- `input_a`  out  WIDTH  operand a to the adder.
- `input_b`  out  WIDTH  operand b to the adder.
- `input_a_stb`  out  1  `input_a` is valid.
- `input_b_stb`  out  1  `input_b` is valid.
- `input_a_ack`  in  1  the adder accepts a.
- `input_b_ack`  in  1  the adder accepts b.
- `pending`  out  clog2(DEPTH)+1  number of pairs held, including the pair being issued.
- `issued`  out  16  count of completed pairs; wraps at 2^16.

## Operation

- Push: `in_valid && in_ready` at a rising edge writes the pair at the tail.
- `in_ready = (pending != DEPTH)`. It is combinational from the count only and does not look at a same-cycle pop. There is no bypass path.
- `input_a`/`input_b` are read combinationally from the head entry. They are stable while the corresponding stb is high.
- A transfer on a side happens when `stb && ack` are both high at a rising edge.
- Issue FSM states:
  - IDLE: both stbs low.
  - BOTH: both stbs high.
  - WAIT_A: only `input_a_stb` high; b is already transferred.
  - WAIT_B: only `input_b_stb` high; a is already transferred.
- Transitions:
  - IDLE→BOTH when `pending != 0`.
  - BOTH→WAIT_B on an a-transfer alone.
  - BOTH→WAIT_A on a b-transfer alone.
  - BOTH, WAIT_A or WAIT_B → final on completion of the remaining transfer(s), including both in the same cycle.
- Final transfer:
  - Pop the head and increment `issued`.
  - Next state is BOTH if (pending − 1 + push) > 0, else IDLE.
- Simultaneous push and pop: `pending` is unchanged and pointers advance independently.
- Pointers are clog2(DEPTH) bits and wrap naturally.
- An ack while the corresponding stb is low is ignored.

## Timing

- Reset values:
  - `input_a_stb` = `input_b_stb` = 0.
  - `in_ready` = 1.
  - `pending` = 0, `issued` = 0.
  - `input_a` = `input_b` = 0; FIFO storage resets to 0.
  - FSM in IDLE.
- Latency: a pair pushed into an empty FIFO at edge k drives both stbs high from edge k+1.
- Back-to-back: if the final transfer occurs at edge k and another pair is held, the next pair's data and both stbs are valid from edge k.
- Each stb drops in the cycle after its own transfer edge, unless the pair completed and a new pair follows.
- Full: `in_ready` is low while `pending == DEPTH`. It rises the cycle after a pop.
- Reset mid-operation: assertion immediately clears stbs, FIFO, counters and FSM. In-flight pairs are discarded, with no partial-issue recovery. `fpu_adder` shares the same reset domain, through inversion at the top level.

## Structure

- Package `fpu_pkg` holds:
  - `WIDTH` selection from the `FPU16`/`FPU32`/`FPU64` defines.
  - The issue-state enum (IDLE, BOTH, WAIT_A, WAIT_B).
  - The `issued` width constant (16).
- Sub-module `fpu_pair_fifo`: a 2×WIDTH-wide FIFO with push/pop, count and combinational head read.
- The top module holds only the issue FSM and the `issued` counter.

## Test plan

- Single pair: push a=0x3F800000, b=0x40000000. Adder model acks a at cycle 3 and b at cycle 5. Expect:
  - stbs high from cycle 1.
  - WAIT_B during cycles 4–5.
  - `issued`=1 and `pending`=0 after the b-ack edge.
- Fill to full: push 5 pairs into `DEPTH`=4 with the adder stalled (no acks). Expect:
  - `in_ready`=0 after 4 pushes, and the 5th pair held upstream.
  - `pending`=4 and `input_a` equal to pair 1.
- Back-to-back: 4 queued pairs and an adder acking a and b together every cycle. Expect:
  - Stbs never drop.
  - A new head each cycle, in order.
  - `issued` 0→4 across four consecutive edges.
- Reversed ack order: b acked first at cycle 2, a at cycle 4. Expect:
  - WAIT_A state.
  - `input_b_stb` low from cycle 3 and `input_a` unchanged.
  - Pop at the cycle-4 edge.
- Wrap: issue 70000 pairs through a random-latency ack model. Expect:
  - `issued` = 70000 mod 65536 = 4464.
  - Every pair observed at the adder in order, with no duplicates.
- Async reset while in WAIT_B with 3 pairs held. Expect:
  - Stbs low within the same cycle.
  - `pending`=0, `in_ready`=1, `issued`=0.
  - Normal issue after `rst` returns high.
